// File: rtl/oneshot_pkg.sv
// Shared state encoding and default sizing for the multi-channel one-shot.
package oneshot_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DELAY = 2'd1,
        PULSE = 2'd2
    } state_e;

    localparam int DEF_NUM_CH = 4;
    localparam int DEF_CNT_W  = 8;

endpackage

// File: rtl/oneshot_chan.sv
// One edge-triggered one-shot channel: IDLE -> DELAY -> PULSE -> IDLE.
// Define ONESHOT_RETRIGGER_EN to let a trigger during PULSE reload the width counter.
module oneshot_chan
    import oneshot_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             trig,
    input  logic [CNT_W-1:0] delay,
    input  logic [CNT_W-1:0] width,
    output logic             q,
    output logic             q_bar,
    output logic             busy,
    output logic             miss
);

    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] wid_q, wid_d;
    logic             q_q, q_d;
    logic             q_bar_q;
    logic             miss_q, miss_d;
    logic             trig_dly_q;
    logic             accept;
    logic             start;

    // A zero-width trigger is dropped everywhere, so it never starts a pulse or flags a miss.
    assign accept = trig && !trig_dly_q && (width != '0);
    assign start  = accept && ((state_q == IDLE) || (state_q == PULSE && cnt_q == ONE));

    always_comb begin
        // NOTE: every _d gets its hold value first, so no path through this block infers a latch.
        state_d = state_q;
        cnt_d   = cnt_q;
        wid_d   = wid_q;
        miss_d  = 1'b0;
        if (start) begin
            if (delay == '0) begin
                state_d = PULSE;
                cnt_d   = width;
            end else begin
                state_d = DELAY;
                cnt_d   = delay;
                wid_d   = width;
            end
        end else begin
            case (state_q)
                DELAY: begin
                    miss_d = accept;
                    if (cnt_q == ONE) begin
                        state_d = PULSE;
                        cnt_d   = wid_q;
                    end else begin
                        cnt_d = cnt_q - ONE;
                    end
                end
                PULSE: begin
                    if (cnt_q == ONE) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else begin
`ifdef ONESHOT_RETRIGGER_EN
                        cnt_d = accept ? width : cnt_q - ONE;
`else
                        cnt_d  = cnt_q - ONE;
                        miss_d = accept;
`endif
                    end
                end
                default: ;
            endcase
        end
        q_d = (state_d == PULSE);
    end

    // NOTE: non-blocking assignments so every flop samples pre-edge values regardless of order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            wid_q      <= '0;
            q_q        <= 1'b0;
            q_bar_q    <= 1'b1;
            miss_q     <= 1'b0;
            trig_dly_q <= 1'b1; // a Trig held high through reset release must not fire
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            wid_q      <= wid_d;
            q_q        <= q_d;
            q_bar_q    <= ~q_d;
            miss_q     <= miss_d;
            trig_dly_q <= trig;
        end
    end

    assign q     = q_q;
    assign q_bar = q_bar_q;
    assign busy  = (state_q != IDLE);
    assign miss  = miss_q;

endmodule

// File: rtl/multi_oneshot.sv
// NUM_CH independent one-shot channels sharing one clock and reset.
// Retrigger-in-PULSE behaviour is selected per build with ONESHOT_RETRIGGER_EN.
module multi_oneshot
    import oneshot_pkg::*;
#(
    parameter int NUM_CH = DEF_NUM_CH,
    parameter int CNT_W  = DEF_CNT_W
) (
    input  logic                    Clk,
    input  logic                    Reset,
    input  logic [NUM_CH-1:0]       Trig,
    input  logic [NUM_CH*CNT_W-1:0] Delay,
    input  logic [NUM_CH*CNT_W-1:0] Width,
    output logic [NUM_CH-1:0]       Q,
    output logic [NUM_CH-1:0]       Q_bar,
    output logic [NUM_CH-1:0]       Busy,
    output logic [NUM_CH-1:0]       Miss
);

    for (genvar i = 0; i < NUM_CH; i++) begin : g_chan
        oneshot_chan #(
            .CNT_W(CNT_W)
        ) u_chan (
            .clk  (Clk),
            .rst  (Reset),
            .trig (Trig[i]),
            .delay(Delay[i*CNT_W +: CNT_W]),
            .width(Width[i*CNT_W +: CNT_W]),
            .q    (Q[i]),
            .q_bar(Q_bar[i]),
            .busy (Busy[i]),
            .miss (Miss[i])
        );
    end

endmodule

// File: tb/tb_multi_oneshot.sv
// Self-checking bench for multi_oneshot: directed scenarios plus random traffic,
// compared against an edge-number model of each channel's pulse window.
module tb_multi_oneshot;

    localparam int NUM_CH = 4;
    localparam int CNT_W  = 8;

    logic                    Clk;
    logic                    Reset;
    logic [NUM_CH-1:0]       Trig;
    logic [NUM_CH*CNT_W-1:0] Delay;
    logic [NUM_CH*CNT_W-1:0] Width;
    logic [NUM_CH-1:0]       Q;
    logic [NUM_CH-1:0]       Q_bar;
    logic [NUM_CH-1:0]       Busy;
    logic [NUM_CH-1:0]       Miss;

    multi_oneshot #(
        .NUM_CH(NUM_CH),
        .CNT_W (CNT_W)
    ) dut (
        .Clk  (Clk),
        .Reset(Reset),
        .Trig (Trig),
        .Delay(Delay),
        .Width(Width),
        .Q    (Q),
        .Q_bar(Q_bar),
        .Busy (Busy),
        .Miss (Miss)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    int checks   = 0;
    int failures = 0;

    // Model: each channel is described by the edge numbers where it was accepted (k),
    // where Q rises (s) and where Q falls / Busy drops (e). Value "after edge n" is
    // Busy = k<=n<e, Q = s<=n<e.
    longint n;
    longint k_m [NUM_CH];
    longint s_m [NUM_CH];
    longint e_m [NUM_CH];
    bit     prev_m [NUM_CH];
    bit     miss_m [NUM_CH];

    int q_cnt    [NUM_CH];
    int busy_cnt [NUM_CH];
    int miss_cnt [NUM_CH];
    int rise_cnt [NUM_CH];
    logic [NUM_CH-1:0] q_prev;

    task automatic check(input string tag, input logic [NUM_CH-1:0] obs, input logic [NUM_CH-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b (edge %0d)", tag, obs, exp, n);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NUM_CH; i++) begin
            k_m[i]    = n;
            s_m[i]    = n;
            e_m[i]    = n;
            prev_m[i] = 1'b1;
            miss_m[i] = 1'b0;
        end
    endtask

    task automatic clear_stats();
        for (int i = 0; i < NUM_CH; i++) begin
            q_cnt[i]    = 0;
            busy_cnt[i] = 0;
            miss_cnt[i] = 0;
            rise_cnt[i] = 0;
        end
        q_prev = Q;
    endtask

    task automatic set_ch(input int ch, input int d, input int w);
        Delay[ch*CNT_W +: CNT_W] = CNT_W'(d);
        Width[ch*CNT_W +: CNT_W] = CNT_W'(w);
    endtask

    // One rising edge: advance the model with the inputs seen at that edge, then compare.
    task automatic tick();
        logic [NUM_CH-1:0] exp_q, exp_b, exp_m;
        longint d, w;
        bit     trig_edge;
        @(posedge Clk);
        n++;
        for (int i = 0; i < NUM_CH; i++) begin
            d         = longint'(Delay[i*CNT_W +: CNT_W]);
            w         = longint'(Width[i*CNT_W +: CNT_W]);
            trig_edge = Trig[i] && !prev_m[i];
            prev_m[i] = Trig[i];
            miss_m[i] = 1'b0;
            if (trig_edge && w != 0) begin
                if (n >= e_m[i]) begin
                    // idle, or the final pulse cycle: a fresh trigger
                    k_m[i] = n;
                    s_m[i] = n + d;
                    e_m[i] = n + d + w;
                end else if (n - 1 < s_m[i]) begin
                    miss_m[i] = 1'b1;
                end else begin
`ifdef ONESHOT_RETRIGGER_EN
                    e_m[i] = n + w;
`else
                    miss_m[i] = 1'b1;
`endif
                end
            end
            exp_q[i] = (s_m[i] <= n) && (n < e_m[i]);
            exp_b[i] = (k_m[i] <= n) && (n < e_m[i]);
            exp_m[i] = miss_m[i];
        end
        #1;
        check("q", Q, exp_q);
        check("q_bar", Q_bar, ~exp_q);
        check("busy", Busy, exp_b);
        check("miss", Miss, exp_m);
        for (int i = 0; i < NUM_CH; i++) begin
            q_cnt[i]    += int'(Q[i]);
            busy_cnt[i] += int'(Busy[i]);
            miss_cnt[i] += int'(Miss[i]);
            rise_cnt[i] += int'(Q[i] && !q_prev[i]);
        end
        q_prev = Q;
    endtask

    task automatic run(input int cycles);
        repeat (cycles) tick();
    endtask

    initial begin
        n     = 0;
        Reset = 1'b0;
        Trig  = '0;
        Delay = '0;
        Width = '0;

        // Reset state, applied asynchronously between edges
        #3 Reset = 1'b1;
        #1;
        check("rst_q", Q, '0);
        check("rst_q_bar", Q_bar, '1);
        check("rst_busy", Busy, '0);
        check("rst_miss", Miss, '0);
        model_reset();
        repeat (2) @(posedge Clk);
        @(negedge Clk);
        Reset = 1'b0;
        run(3);

        // ch0: D=3, W=5
        set_ch(0, 3, 5);
        clear_stats();
        Trig[0] = 1'b1;
        tick();
        Trig[0] = 1'b0;
        run(14);
        check_int("ch0_d3w5_q_cycles", q_cnt[0], 5);
        check_int("ch0_d3w5_busy_cycles", busy_cnt[0], 8);

        // ch1: D=0, W=1, trigger held high 20 cycles
        set_ch(1, 0, 1);
        clear_stats();
        Trig[1] = 1'b1;
        run(20);
        Trig[1] = 1'b0;
        run(2);
        check_int("ch1_held_q_cycles", q_cnt[1], 1);
        check_int("ch1_held_miss", miss_cnt[1], 0);

        // ch2: D=0, W=10, second edge 4 cycles after the first
        set_ch(2, 0, 10);
        clear_stats();
        Trig[2] = 1'b1;
        tick();
        Trig[2] = 1'b0;
        run(3);
        Trig[2] = 1'b1;
        tick();
        Trig[2] = 1'b0;
        run(20);
`ifdef ONESHOT_RETRIGGER_EN
        check_int("ch2_retrig_q_cycles", q_cnt[2], 14);
        check_int("ch2_retrig_miss", miss_cnt[2], 0);
`else
        check_int("ch2_retrig_q_cycles", q_cnt[2], 10);
        check_int("ch2_retrig_miss", miss_cnt[2], 1);
`endif

        // ch0: D=0, W=3, new edge in the final pulse cycle
        set_ch(0, 0, 3);
        clear_stats();
        Trig[0] = 1'b1;
        tick();
        Trig[0] = 1'b0;
        run(2);
        Trig[0] = 1'b1;
        tick();
        Trig[0] = 1'b0;
        run(6);
        check_int("ch0_final_cycle_q_cycles", q_cnt[0], 6);
        check_int("ch0_final_cycle_rises", rise_cnt[0], 1);
        check_int("ch0_final_cycle_miss", miss_cnt[0], 0);

        // All channels on one edge: W=0 on ch0, W=255 on ch1
        set_ch(0, 2, 0);
        set_ch(1, 0, 255);
        set_ch(2, 1, 4);
        set_ch(3, 5, 2);
        clear_stats();
        Trig = '1;
        tick();
        Trig = '0;
        run(265);
        check_int("ch0_w0_q_cycles", q_cnt[0], 0);
        check_int("ch0_w0_busy_cycles", busy_cnt[0], 0);
        check_int("ch1_w255_q_cycles", q_cnt[1], 255);
        check_int("ch2_indep_q_cycles", q_cnt[2], 4);
        check_int("ch3_indep_q_cycles", q_cnt[3], 2);

        // ch3: D=2, W=4, reset mid-pulse with Trig high at release
        set_ch(3, 2, 4);
        clear_stats();
        Trig[3] = 1'b1;
        tick();
        Trig[3] = 1'b0;
        run(3);
        check("ch3_in_pulse", Q, 4'b1000);
        Trig[3] = 1'b1;
        #3 Reset = 1'b1;
        #1;
        check("rst_mid_q", Q, '0);
        check("rst_mid_busy", Busy, '0);
        check("rst_mid_q_bar", Q_bar, '1);
        model_reset();
        repeat (2) @(posedge Clk);
        @(negedge Clk);
        Reset = 1'b0;
        clear_stats();
        run(10);
        check_int("ch3_held_at_release_q_cycles", q_cnt[3], 0);
        Trig[3] = 1'b0;
        run(2);

        // Random traffic, delay/width changing every cycle
        for (int t = 0; t < 600; t++) begin
            for (int i = 0; i < NUM_CH; i++) begin
                Trig[i] = ($urandom_range(0, 3) == 0);
                set_ch(i, int'($urandom_range(0, 5)), int'($urandom_range(1, 7)));
            end
            tick();
        end
        Trig = '0;
        run(20);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/multi_oneshot.md
MULTI_ONESHOT -- requirements
Module: multi_oneshot

Interface
REQ-001 SHALL have parameter NUM_CH, default 4, number of independent one-shot channels.
REQ-002 SHALL have parameter CNT_W, default 8, width of per-channel delay and width fields.
REQ-003 SHALL have port Clk  input  1  sole clock; all state changes on rising edge.
REQ-004 SHALL have port Reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port Trig  input  NUM_CH  per-channel trigger, synchronous to Clk.
REQ-006 SHALL have port Delay  input  NUM_CH*CNT_W  per-channel delay in cycles; channel i is bits [i*CNT_W +: CNT_W].
REQ-007 SHALL have port Width  input  NUM_CH*CNT_W  per-channel pulse width in cycles; same slicing as Delay.
REQ-008 SHALL have port Q  output  NUM_CH  pulse output, registered.
REQ-009 SHALL have port Q_bar  output  NUM_CH  always the inverse of Q, registered.
REQ-010 SHALL have port Busy  output  NUM_CH  high when the channel is not IDLE.
REQ-011 SHALL have port Miss  output  NUM_CH  one-cycle pulse when a trigger edge is ignored.

Function
REQ-012 Each channel SHALL detect a trigger as Trig=1 sampled with the previous registered sample Trig_d=0.
REQ-013 Each channel SHALL run the FSM IDLE -> DELAY -> PULSE -> IDLE.
REQ-014 Delay and Width SHALL be captured at the accepting edge; later input changes SHALL NOT affect a pulse in progress.
REQ-015 For a trigger accepted at edge k, Q SHALL be high after edge k+D through edge k+D+W, exactly W cycles, and low after edge k+D+W.
REQ-016 With D=0, IDLE SHALL go directly to PULSE at edge k; with D>0 it SHALL go to DELAY and count D cycles.
REQ-017 With W=0, the trigger SHALL be discarded: no state change, no Q pulse, no Miss.
REQ-018 A trigger edge in DELAY SHALL be ignored and SHALL assert Miss for one cycle.
REQ-019 A trigger edge in PULSE SHALL be handled per REQ-026/REQ-027.
REQ-020 A trigger edge in the final PULSE cycle SHALL be accepted as a new trigger, with no Miss; with D=0, Q SHALL stay continuously high.
REQ-021 Counters SHALL be CNT_W wide and SHALL never wrap; the maximum pulse is 2^CNT_W-1 cycles.
REQ-022 Channels SHALL be fully independent; simultaneous triggers on all channels SHALL each be accepted.

Reset
REQ-023 On Reset, every channel SHALL immediately go to IDLE with Q=0, Q_bar=1, Busy=0, Miss=0 and counters=0, including mid-pulse.
REQ-024 Trig_d SHALL reset to 1, so a Trig held high through reset release SHALL NOT fire.
REQ-025 Reset SHALL be asserted asynchronously; release SHALL be assumed synchronous to Clk by the source.

Configuration
REQ-026 Macro ONESHOT_RETRIGGER_EN defined: a trigger edge in PULSE SHALL reload the width counter from Width without a Miss; Q SHALL stay high and fall W cycles after the retrigger edge.
REQ-027 Macro ONESHOT_RETRIGGER_EN undefined: a trigger edge in PULSE (other than the final cycle) SHALL be ignored and SHALL assert Miss for one cycle.

Structure
REQ-028 Package oneshot_pkg SHALL hold the state enum (IDLE, DELAY, PULSE) and the default NUM_CH and CNT_W constants.
REQ-029 Per-channel logic SHALL be sub-module oneshot_chan, instantiated NUM_CH times via generate.

Verification
REQ-030 Ch0 D=3, W=5, Trig rises before edge 10 -> Q0 high after edges 13..18 (5 cycles), Busy0 high after edges 10..18, Q_bar0 = ~Q0 throughout.
REQ-031 Ch1 D=0, W=1; Trig held high 20 cycles -> exactly one 1-cycle Q1 pulse after the edge; no Miss.
REQ-032 Ch2 D=0, W=10, second edge 4 cycles after the first -> with macro: Q2 high 14 cycles, Miss2=0; without macro: Q2 high 10 cycles, one Miss2 pulse.
REQ-033 Ch3 D=2, W=4, Reset asserted mid-PULSE -> Q3=0, Busy3=0 immediately (asynchronously); Trig high at release -> no pulse.
REQ-034 All channels triggered on the same edge with W=0 on ch0 and W=255 on ch1 -> ch0 no activity; ch1 Q high exactly 255 cycles; others independent.
REQ-035 Ch0 D=0, W=3, new edge in the final PULSE cycle -> Q0 continuously high 6 cycles, Miss0=0.
